// File: rtl/pwm_ramp_adc_mc.sv
// pwm_ramp_adc_mc: PWM-DAC plus comparator ADC with ramp or SAR search,
// round-robin over the enabled comparator channels.
module pwm_ramp_adc_mc #(
   parameter int NBITS          = 6,
   parameter int NCH            = 4,
   parameter int SETTLE_PERIODS = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   enable_i,
   input  logic                                   mode_i,
   input  logic [NBITS-1:0]                       step_i,
   input  logic [NCH-1:0]                         ch_mask_i,
   input  logic [NCH-1:0]                         lvds_i,
   output logic                                   pwm_o,
   output logic [NBITS-1:0]                       dc_o,
   output logic                                   busy_o,
   output logic [NBITS-1:0]                       result_o,
   output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] result_ch_o,
   output logic                                   result_ovf_o,
   output logic                                   result_valid_o,
   input  logic                                   result_ready_i
);
   localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
   localparam int PW = SETTLE_PERIODS > 1 ? $clog2(SETTLE_PERIODS) : 1;
   localparam logic [NBITS-1:0] MAXV = '1;
   localparam logic [NBITS-1:0] MSB = NBITS'(1) << (NBITS - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, OUT} state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] cnt_q, cnt_d, dc_d, res_d, trial_q, trial_d, step_q, step_d, sar_dc;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             mode_q, mode_d, ovf_d, comp;
   logic [CW-1:0]    ch_q, ch_d, rch_d, nxt_ch, idx;
   logic [NCH-1:0]   sync1_q, sync2_q;
   logic [NBITS:0]   ramp_sum;

   assign comp           = sync2_q[ch_q];
   assign ramp_sum       = {1'b0, dc_o} + {1'b0, step_q};
   assign sar_dc         = comp ? dc_o & ~trial_q : dc_o;
   assign busy_o         = state_q == SETTLE || state_q == COMPARE;
   assign result_valid_o = state_q == OUT;

   // ch_q holds the previous channel; scanning downward leaves the nearest set bit above it
   always_comb begin
      nxt_ch = ch_q;
      idx    = '0;
      for (int i = NCH; i >= 1; i--) begin
         idx = CW'((int'(ch_q) + i) % NCH);
         if (ch_mask_i[idx]) nxt_ch = idx;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      pcnt_d  = pcnt_q;
      dc_d    = dc_o;
      trial_d = trial_q;
      step_d  = step_q;
      mode_d  = mode_q;
      ch_d    = ch_q;
      res_d   = result_o;
      ovf_d   = result_ovf_o;
      rch_d   = result_ch_o;
      case (state_q)
         IDLE: if (enable_i && |ch_mask_i) begin
            state_d = SETTLE;
            cnt_d   = '0;
            pcnt_d  = '0;
            mode_d  = mode_i;
            step_d  = step_i == '0 ? NBITS'(1) : step_i;
            ch_d    = nxt_ch;
            trial_d = MSB;
            dc_d    = mode_i ? MSB : '0;
         end
         SETTLE: if (!enable_i) begin
            state_d = IDLE;
            dc_d    = '0;
         end else if (cnt_q == MAXV) begin
            pcnt_d = pcnt_q + 1'b1;
            if (pcnt_q == PW'(SETTLE_PERIODS - 1)) begin
               state_d = COMPARE;
               pcnt_d  = '0;
            end
         end
         COMPARE: begin
            // cnt parks at 0 so every settle window starts on a period boundary
            cnt_d = '0;
            if (!enable_i) begin
               state_d = IDLE;
               dc_d    = '0;
            end else if (!mode_q) begin
               if (comp || ramp_sum > {1'b0, MAXV}) begin
                  state_d = OUT;
                  rch_d   = ch_q;
                  ovf_d   = !comp;
                  res_d   = comp ? (dc_o == '0 ? '0 : dc_o - 1'b1) : MAXV;
               end else begin
                  state_d = SETTLE;
                  dc_d    = ramp_sum[NBITS-1:0];
               end
            end else if (trial_q[0]) begin
               state_d = OUT;
               dc_d    = sar_dc;
               res_d   = sar_dc;
               ovf_d   = 1'b0;
               rch_d   = ch_q;
            end else begin
               state_d = SETTLE;
               dc_d    = sar_dc | (trial_q >> 1);
               trial_d = trial_q >> 1;
            end
         end
         OUT: if (result_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pcnt_q       <= '0;
         dc_o         <= '0;
         pwm_o        <= 1'b0;
         trial_q      <= '0;
         step_q       <= '0;
         mode_q       <= 1'b0;
         ch_q         <= CW'(NCH - 1);
         result_o     <= '0;
         result_ovf_o <= 1'b0;
         result_ch_o  <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pcnt_q       <= pcnt_d;
         dc_o         <= dc_d;
         pwm_o        <= cnt_q < dc_o;
         trial_q      <= trial_d;
         step_q       <= step_d;
         mode_q       <= mode_d;
         ch_q         <= ch_d;
         result_o     <= res_d;
         result_ovf_o <= ovf_d;
         result_ch_o  <= rch_d;
         sync1_q      <= lvds_i;
         sync2_q      <= sync1_q;
      end
   end
endmodule

// File: tb/tb_pwm_ramp_adc_mc.sv
// tb_pwm_ramp_adc_mc: randomized bench for pwm_ramp_adc_mc; comparators are modelled
// as per-channel thresholds on the duty code.
module tb_pwm_ramp_adc_mc;
   localparam int NB   = 6;
   localparam int NC   = 4;
   localparam int SP   = 2;
   localparam int MAXC = 2**NB - 1;
   localparam int PER  = SP * (2**NB) + 1;

   logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mode = 1'b0, ready = 1'b0;
   logic [NB-1:0] step = '0;
   logic [NC-1:0] mask = '0, lvds;
   logic          pwm, busy, valid, ovf;
   logic [NB-1:0] dc, res;
   logic [1:0]    rch;
   int            thr [NC];
   int            n_cmp = 0, n_bad = 0;
   int            dc_seq [$];

   pwm_ramp_adc_mc #(.NBITS(NB), .NCH(NC), .SETTLE_PERIODS(SP)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mode_i(mode), .step_i(step),
      .ch_mask_i(mask), .lvds_i(lvds), .pwm_o(pwm), .dc_o(dc), .busy_o(busy),
      .result_o(res), .result_ch_o(rch), .result_ovf_o(ovf), .result_valid_o(valid),
      .result_ready_i(ready)
   );

   always #5 clk = ~clk;

   always_comb for (int i = 0; i < NC; i++) lvds[i] = int'(dc) >= thr[i];

   // ramp: codes 0, s, 2s, ... until one reaches the threshold or the next would overflow
   function automatic void ramp_ref(input int t, input int s_in, output int r, output int o,
                                    output int n, output int fdc);
      int d = 0;
      int s = s_in == 0 ? 1 : s_in;
      bit done = 0;
      n = 0; r = 0; o = 0; fdc = 0;
      while (!done) begin
         n++;
         if (d >= t) begin
            r = d == 0 ? 0 : d - 1; o = 0; fdc = d; done = 1;
         end else if (d + s > MAXC) begin
            r = MAXC; o = 1; fdc = d; done = 1;
         end else d += s;
      end
   endfunction

   // SAR: largest code strictly below the threshold, clamped to the code range
   function automatic void sar_ref(input int t, output int r, output int o, output int n,
                                   output int fdc);
      r = t <= 0 ? 0 : (t - 1 > MAXC ? MAXC : t - 1);
      o = 0; n = NB; fdc = r;
   endfunction

   task automatic run_conv(input int ch, input logic m, input logic [NB-1:0] s, output int r,
                           output int c, output int o, output int cyc, output int duty,
                           output bit ok);
      int w = 0;
      ok = 0; cyc = 0; duty = 0; r = -1; c = -1; o = -1;
      dc_seq.delete();
      @(negedge clk);
      mask = NC'(1) << ch; mode = m; step = s; enable = 1; ready = 0;
      while (!busy && w < 10) begin @(negedge clk); w++; end
      if (!busy) begin enable = 0; return; end
      dc_seq.push_back(int'(dc));
      while (cyc < 20000) begin
         @(posedge clk); cyc++; @(negedge clk);
         if (valid) begin ok = 1; break; end
         if (busy && int'(dc) != dc_seq[$]) dc_seq.push_back(int'(dc));
      end
      enable = 0;
      if (!ok) return;
      r = int'(res); c = int'(rch); o = int'(ovf);
      for (int i = 0; i < 2**NB; i++) begin @(negedge clk); duty += int'(pwm); end
      ready = 1; @(negedge clk); ready = 0;
   endtask

   task automatic test_reset;
      rst_n = 0; enable = 0; ready = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({pwm, busy, valid, ovf} !== 4'b0) begin n_bad++;
         $display("FAIL reset_flags: got %b expected 0000", {pwm, busy, valid, ovf}); end
      n_cmp++; if ({dc, res, rch} !== '0) begin n_bad++;
         $display("FAIL reset_values: got dc=%0d res=%0d ch=%0d expected 0", dc, res, rch); end
      rst_n = 1;
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, valid, dc} !== '0) begin n_bad++;
         $display("FAIL idle_after_reset: got busy=%b valid=%b dc=%0d expected 0", busy, valid, dc); end
   endtask

   task automatic test_ramp;
      int r, c, o, cyc, duty, er, eo, en, ef;
      bit ok;
      thr[0] = 37;
      ramp_ref(37, 1, er, eo, en, ef);
      run_conv(0, 1'b0, NB'(1), r, c, o, cyc, duty, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ramp_timeout: got no valid expected valid"); end
      n_cmp++; if (r !== er || c !== 0 || o !== eo) begin n_bad++;
         $display("FAIL ramp_result: got r=%0d ch=%0d ovf=%0d expected r=%0d ch=0 ovf=%0d", r, c, o, er, eo); end
      n_cmp++; if (cyc !== en * PER) begin n_bad++;
         $display("FAIL ramp_latency: got %0d expected %0d", cyc, en * PER); end
      n_cmp++; if (duty !== ef) begin n_bad++;
         $display("FAIL ramp_pwm_duty: got %0d expected %0d", duty, ef); end
   endtask

   task automatic test_sar;
      int r, c, o, cyc, duty, er, eo, en, ef;
      int exp_seq [6] = '{32, 48, 40, 36, 38, 37};
      bit ok;
      thr[0] = 37;
      sar_ref(37, er, eo, en, ef);
      run_conv(0, 1'b1, NB'(9), r, c, o, cyc, duty, ok);
      n_cmp++; if (!ok || r !== er || o !== eo) begin n_bad++;
         $display("FAIL sar_result: got ok=%0d r=%0d ovf=%0d expected r=%0d ovf=%0d", ok, r, o, er, eo); end
      n_cmp++; if (cyc !== en * PER) begin n_bad++;
         $display("FAIL sar_latency: got %0d expected %0d", cyc, en * PER); end
      n_cmp++; if (dc_seq.size() !== 6) begin n_bad++;
         $display("FAIL sar_seq_len: got %0d expected 6", dc_seq.size()); end
      for (int i = 0; i < 6 && i < dc_seq.size(); i++) begin
         n_cmp++; if (dc_seq[i] !== exp_seq[i]) begin n_bad++;
            $display("FAIL sar_seq[%0d]: got %0d expected %0d", i, dc_seq[i], exp_seq[i]); end
      end
      n_cmp++; if (duty !== ef) begin n_bad++;
         $display("FAIL sar_pwm_duty: got %0d expected %0d", duty, ef); end
   endtask

   task automatic test_full_scale;
      int r, c, o, cyc, duty, er, eo, en, ef;
      bit ok;
      thr[0] = 1000;
      ramp_ref(1000, 5, er, eo, en, ef);
      run_conv(0, 1'b0, NB'(5), r, c, o, cyc, duty, ok);
      n_cmp++; if (!ok || r !== er || o !== eo) begin n_bad++;
         $display("FAIL fullscale_result: got ok=%0d r=%0d ovf=%0d expected r=%0d ovf=%0d", ok, r, o, er, eo); end
      n_cmp++; if (dc_seq.size() !== en || cyc !== en * PER) begin n_bad++;
         $display("FAIL fullscale_steps: got %0d codes %0d cycles expected %0d codes %0d cycles",
                  dc_seq.size(), cyc, en, en * PER); end
      n_cmp++; if (duty !== ef) begin n_bad++;
         $display("FAIL fullscale_pwm_duty: got %0d expected %0d", duty, ef); end
   endtask

   task automatic test_step_zero;
      int r, c, o, cyc, duty, er, eo, en, ef;
      bit ok;
      thr[2] = 3;
      ramp_ref(3, 0, er, eo, en, ef);
      run_conv(2, 1'b0, NB'(0), r, c, o, cyc, duty, ok);
      n_cmp++; if (!ok || r !== er || c !== 2 || cyc !== en * PER) begin n_bad++;
         $display("FAIL step_zero: got r=%0d ch=%0d cyc=%0d expected r=%0d ch=2 cyc=%0d", r, c, cyc, er, en * PER); end
   endtask

   task automatic test_random;
      int r, c, o, cyc, duty, er, eo, en, ef, ch, s;
      logic m;
      bit ok;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NC; i++) thr[i] = $urandom_range(0, 70);
         ch = $urandom_range(0, NC - 1);
         m  = it == 0 ? 1'b0 : 1'($urandom_range(0, 1));
         s  = $urandom_range(4, 15);
         if (it == 0) thr[ch] = 0;
         if (m) sar_ref(thr[ch], er, eo, en, ef);
         else ramp_ref(thr[ch], s, er, eo, en, ef);
         run_conv(ch, m, NB'(s), r, c, o, cyc, duty, ok);
         n_cmp++; if (!ok || r !== er || c !== ch || o !== eo) begin n_bad++;
            $display("FAIL rand%0d_result: got ok=%0d r=%0d ch=%0d ovf=%0d expected r=%0d ch=%0d ovf=%0d (mode %0d thr %0d step %0d)",
                     it, ok, r, c, o, er, ch, eo, m, thr[ch], s); end
         n_cmp++; if (cyc !== en * PER || duty !== ef) begin n_bad++;
            $display("FAIL rand%0d_timing: got cyc=%0d duty=%0d expected cyc=%0d duty=%0d", it, cyc, duty, en * PER, ef); end
      end
   endtask

   task automatic test_back_to_back;
      int w = 0, bad = 0, er, eo, en, ef;
      int exp_ch [3] = '{1, 3, 1};
      int got_ch [$], got_r [$];
      logic [NB-1:0] r0, d0;
      logic [1:0] c0;
      bit flipped = 0;
      rst_n = 0; @(negedge clk); rst_n = 1;
      thr[0] = 0; thr[1] = 20; thr[2] = 0; thr[3] = 50;
      mask = 4'b1010; mode = 1; step = 3; ready = 0; enable = 1;
      while (!valid && w < 3000) begin @(negedge clk); w++; end
      n_cmp++; if (!valid) begin n_bad++; $display("FAIL b2b_first_valid: got no valid expected valid"); end
      r0 = res; c0 = rch; d0 = dc;
      repeat (500) begin
         @(negedge clk);
         if (!valid || res !== r0 || rch !== c0 || busy || dc !== d0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++;
         $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad); end
      ready = 1; w = 0;
      while (got_ch.size() < 3 && w < 5000) begin
         if (valid) begin
            got_ch.push_back(int'(rch)); got_r.push_back(int'(res)); mode = 1; step = 3;
         end else if (busy && got_ch.size() == 1 && !flipped) begin
            mode = 0; step = 7; flipped = 1;
         end
         if (got_ch.size() < 3) begin @(negedge clk); w++; end
      end
      enable = 0;
      @(negedge clk); ready = 0;
      n_cmp++; if (got_ch.size() !== 3) begin n_bad++;
         $display("FAIL rr_count: got %0d expected 3", got_ch.size()); end
      for (int i = 0; i < got_ch.size(); i++) begin
         sar_ref(thr[exp_ch[i]], er, eo, en, ef);
         n_cmp++; if (got_ch[i] !== exp_ch[i] || got_r[i] !== er) begin n_bad++;
            $display("FAIL rr_result[%0d]: got ch=%0d r=%0d expected ch=%0d r=%0d", i, got_ch[i], got_r[i], exp_ch[i], er); end
      end
   endtask

   task automatic test_abort;
      int w = 0, bad = 0;
      thr[0] = 10;
      @(negedge clk);
      mask = 4'b0001; mode = 1; step = 1; ready = 0; enable = 1;
      while (!busy && w < 10) begin @(negedge clk); w++; end
      n_cmp++; if (!busy) begin n_bad++; $display("FAIL abort_start: got busy=0 expected 1"); end
      repeat ($urandom_range(5, 100)) @(negedge clk);
      enable = 0;
      @(negedge clk);
      n_cmp++; if (dc !== '0 || busy !== 1'b0) begin n_bad++;
         $display("FAIL abort_next: got dc=%0d busy=%b expected dc=0 busy=0", dc, busy); end
      @(negedge clk);
      n_cmp++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL abort_pwm: got %b expected 0", pwm); end
      repeat (300) begin @(negedge clk); if (valid || pwm || dc != '0) bad++; end
      n_cmp++; if (bad !== 0) begin n_bad++;
         $display("FAIL abort_no_result: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_reset_out;
      int w = 0;
      thr[1] = 20; thr[3] = 50;
      @(negedge clk);
      mask = 4'b1010; mode = 1; step = 1; ready = 0; enable = 1;
      while (!valid && w < 3000) begin @(negedge clk); w++; end
      n_cmp++; if (!valid || rch !== 2'd1) begin n_bad++;
         $display("FAIL rst_pre_ch: got valid=%b ch=%0d expected valid=1 ch=1", valid, rch); end
      rst_n = 0;
      #1;
      n_cmp++; if ({pwm, busy, valid, ovf, dc, res, rch} !== '0) begin n_bad++;
         $display("FAIL rst_async: got pwm=%b busy=%b valid=%b ovf=%b dc=%0d res=%0d ch=%0d expected all 0",
                  pwm, busy, valid, ovf, dc, res, rch); end
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_valid: got 1 expected 0"); end
      w = 0;
      while (!valid && w < 3000) begin @(negedge clk); w++; end
      n_cmp++; if (!valid || rch !== 2'd1 || res !== NB'(19)) begin n_bad++;
         $display("FAIL rst_restart: got valid=%b ch=%0d r=%0d expected valid=1 ch=1 r=19", valid, rch, res); end
      enable = 0; ready = 1;
      @(negedge clk); ready = 0;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_sar();
      test_full_scale();
      test_step_zero();
      test_random();
      test_back_to_back();
      test_abort();
      test_reset_out();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pwm_ramp_adc_mc.md
PWM_RAMP_ADC_MC -- requirements
Module: pwm_ramp_adc_mc

Interface
REQ-001 SHALL have parameter NBITS, default 6, meaning PWM duty/result width; PWM period is 2^NBITS clocks.
REQ-002 SHALL have parameter NCH, default 4, meaning number of comparator channels (NCH>=1).
REQ-003 SHALL have parameter SETTLE_PERIODS, default 2, meaning full PWM periods waited after each dc change before sampling (>=1).
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port enable_i, input, 1, meaning run conversions while high.
REQ-007 SHALL have port mode_i, input, 1, meaning 0 = ramp search, 1 = SAR search.
REQ-008 SHALL have port step_i, input, NBITS, meaning ramp increment; a value of 0 is treated as 1.
REQ-009 SHALL have port ch_mask_i, input, NCH, meaning channels enabled for round-robin.
REQ-010 SHALL have port lvds_i, input, NCH, meaning asynchronous comparator outputs, 1 = filtered PWM above channel input.
REQ-011 SHALL have port pwm_o, output, 1, meaning PWM output.
REQ-012 SHALL have port dc_o, output, NBITS, meaning current duty code.
REQ-013 SHALL have port busy_o, output, 1, meaning a conversion is in progress.
REQ-014 SHALL have port result_o, output, NBITS, meaning converted code.
REQ-015 SHALL have port result_ch_o, output, max(1,$clog2(NCH)), meaning channel of result_o.
REQ-016 SHALL have port result_ovf_o, output, 1, meaning ramp reached full scale without trip.
REQ-017 SHALL have port result_valid_o, output, 1, meaning result valid.
REQ-018 SHALL have port result_ready_i, input, 1, meaning consumer accepts the result.

Function
REQ-019 SHALL have PWM counter cnt 0..2^NBITS-1 wrapping, with pwm_o = (cnt < dc_o) registered, so that dc 0 gives constant low.
REQ-020 SHALL pass each lvds_i bit through a 2-flop synchronizer; all comparisons use the synchronized value.
REQ-021 SHALL implement FSM states IDLE, SETTLE, COMPARE, OUT.
REQ-022 IDLE SHALL go to SETTLE when enable_i=1, ch_mask_i!=0 and result_valid_o=0, and on that transition SHALL:
- latch mode_i, step_i and channel;
- clear cnt to 0;
- load dc_o with 0 (ramp) or 2^(NBITS-1) (SAR).
REQ-023 SETTLE SHALL count SETTLE_PERIODS complete PWM periods, then enter COMPARE on the cycle after cnt = 2^NBITS-1.
REQ-024 COMPARE SHALL last one cycle and sample comp = synchronized lvds_i[channel].
REQ-025 In ramp mode, comp=1 SHALL set result = dc_o-1 (0 if dc_o=0) and ovf=0, then go to OUT.
REQ-026 In ramp mode with comp=0, if dc_o+step > 2^NBITS-1 the block SHALL set result = 2^NBITS-1 and ovf=1 and go to OUT; otherwise it SHALL set dc_o += step and return to SETTLE.
REQ-027 In SAR mode, for trial bit k from MSB down, comp=1 SHALL clear bit k; if k>0 the block SHALL set bit k-1 and return to SETTLE; after k=0 it SHALL set result = dc_o and ovf=0 and go to OUT.
REQ-028 A SAR conversion SHALL take exactly NBITS compares.
REQ-029 A conversion SHALL be NBITS compares (SAR) or trip index+1 compares (ramp), each compare SETTLE_PERIODS*2^NBITS+1 cycles long.
REQ-030 OUT SHALL:
- hold result_valid_o=1 with result_o, result_ch_o and result_ovf_o stable until result_valid_o & result_ready_i;
- keep dc_o at its last value;
- go to IDLE after the handshake.
REQ-031 Channel selection SHALL use the lowest set bit of ch_mask_i after reset, and thereafter the next set bit above the previous channel, wrapping to the lowest; the mask SHALL be evaluated only in IDLE.
REQ-032 busy_o SHALL be 1 in SETTLE and COMPARE only.
REQ-033 enable_i=0 in SETTLE or COMPARE SHALL abort to IDLE on the next edge with dc_o=0 and no result produced.
REQ-034 enable_i=0 in OUT SHALL keep the pending result until it is accepted.
REQ-035 Changes to mode_i and step_i mid-conversion SHALL have no effect until the next start.

Reset
REQ-036 While rst_ni=0, the block SHALL reset asynchronously to:
- state IDLE;
- cnt, dc_o, pwm_o, busy_o, result_o, result_ch_o, result_ovf_o and result_valid_o all 0;
- synchronizers 0;
- round-robin pointer at lowest-channel start.
REQ-037 Reset asserted mid-conversion or mid-OUT SHALL discard all state; there SHALL be no valid result after release.

Verification
REQ-038 Ramp test: NBITS=6, SETTLE_PERIODS=2, mask 0001, step 1, lvds[0]=1 iff dc>=37 -> result 36, ch 0, ovf 0, valid 38*129 (+sync) cycles after start.
REQ-039 SAR test: same comparator, mode 1 -> dc sequence 32,48,40,36,38,37 -> result 36 after 6 compares.
REQ-040 Full-scale test: ramp, step 5, lvds always 0 -> dc 0,5,...,60 -> result 63, ovf 1.
REQ-041 Round-robin and backpressure test: mask 1010, ready low for 500 cycles after the first valid.
- While ready is low, valid and result SHALL stay stable, busy_o SHALL stay 0 and dc_o SHALL not change.
- After ready rises, results SHALL arrive for channel order 1,3,1.
REQ-042 Abort test: enable_i dropped during SETTLE -> dc_o=0 and busy_o=0 next cycle, pwm_o=0 within 2 cycles, no valid.
REQ-043 Reset test: rst_ni pulsed low in OUT -> all outputs 0 immediately; the next conversion SHALL start on channel = lowest mask bit.
